// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// width-legality helpers used by the elaboration checks.
package bshift_pkg;

  // Operation select carried down the pipeline with each word.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  localparam int unsigned MinWidth = 4;
  localparam int unsigned MaxWidth = 64;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when w is a legal data width for the shifter.
  function automatic bit width_ok(input int unsigned w);
    return is_pow2(w) && (w >= MinWidth) && (w <= MaxWidth);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional shift of fixed distance DIST, covering all four ops.
// Purely combinational; the top level registers the result.
module shift_stage
  import bshift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_data
);

  if ((DIST == 0) || (DIST >= WIDTH)) begin : g_bad_dist
    $error("shift_stage: DIST must be in 1..WIDTH-1");
  end

  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_ror;

  // All four candidate results at this stage's fixed distance.
  always_comb begin
    w_sll = i_data << DIST;
    w_srl = i_data >> DIST;
    w_sra = $signed(i_data) >>> DIST;
    // Bits leaving the LSB end re-enter at the MSB end.
    w_ror = (i_data >> DIST) | (i_data << (WIDTH - DIST));
  end

  // Select by op when this stage's amount bit is set, else pass through.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      unique case (i_op)
        OP_SLL:  o_data = w_sll;
        OP_SRL:  o_data = w_srl;
        OP_SRA:  o_data = w_sra;
        OP_ROR:  o_data = w_ror;
        default: o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, largest shift
// distance first, with a single global stall driven by the output handshake.
module barrel_shifter_pipe
  import bshift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  // Stage count and amount width; derived, never overridden.
  localparam int unsigned SHW = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two in 4..64");
  end

  // Pipeline registers, one entry per stage.
  logic [WIDTH-1:0] r_data  [SHW];
  logic [SHW-1:0]   r_amt   [SHW];
  op_e              r_op    [SHW];
  logic [SHW-1:0]   r_valid;

  // Per-stage inputs (previous stage or the input port) and shifted result.
  logic [WIDTH-1:0] w_src_data  [SHW];
  logic [SHW-1:0]   w_src_amt   [SHW];
  op_e              w_src_op    [SHW];
  logic [SHW-1:0]   w_src_valid;
  logic [WIDTH-1:0] w_shifted   [SHW];

  logic w_advance;

  // Whole pipeline moves together; it only stops when a result is stuck.
  always_comb begin
    w_advance = !r_valid[SHW-1] || out_ready;
    // Reset forces acceptance visible; the word is discarded by the reset.
    in_ready  = w_advance || rst;
    out_valid = r_valid[SHW-1];
    out_data  = r_data[SHW-1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned AmtBit = SHW - 1 - k;
    localparam int unsigned Dist   = 1 << AmtBit;

    if (k == 0) begin : g_src_port
      assign w_src_data[k]  = in_data;
      assign w_src_amt[k]   = in_amt;
      assign w_src_op[k]    = op_e'(in_op);
      assign w_src_valid[k] = in_valid;
    end else begin : g_src_reg
      assign w_src_data[k]  = r_data[k-1];
      assign w_src_amt[k]   = r_amt[k-1];
      assign w_src_op[k]    = r_op[k-1];
      assign w_src_valid[k] = r_valid[k-1];
    end

    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (Dist)
    ) u_shift (
      .i_data(w_src_data[k]),
      .i_en  (w_src_amt[k][AmtBit]),
      .i_op  (w_src_op[k]),
      .o_data(w_shifted[k])
    );
  end

  // Stage registers: clear on reset, advance together, hold while stalled.
  // Payload loads only with a valid word, so bubbles never sample inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_op[k]   <= OP_SLL;
      end
    end else if (w_advance) begin
      r_valid <= w_src_valid;
      for (int k = 0; k < SHW; k++) begin
        if (w_src_valid[k]) begin
          r_data[k] <= w_shifted[k];
          r_amt[k]  <= w_src_amt[k];
          r_op[k]   <= w_src_op[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed table, stall, reset and randomized-traffic checks for
// barrel_shifter_pipe at WIDTH = 32.
module tb_barrel_shifter_pipe;
  import bshift_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_amt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [15];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_got  = 0;
  logic [31:0] exp_q [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", what, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] a,
                                        input logic [31:0] d);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = $signed(d) >>> a;
      default: r = (a == 0) ? d : ((d >> a) | (d << (6'd32 - {1'b0, a})));
    endcase
    return r;
  endfunction

  // One word through an otherwise empty pipeline; checks latency and result.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_amt    = v.amt;
    in_data   = v.data;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~v.data;
    in_amt   = ~v.amt;
    n = 1;
    while (n <= 12 && !out_valid) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("vec%0d latency", idx), 32'(n), 32'd5);
    check($sformatf("vec%0d data", idx), out_data, v.exp);
  endtask

  // One streaming cycle: drive, observe handshakes, score outputs.
  task automatic do_cycle(input bit iv, input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] d, input bit ordy, output bit acc);
    @(negedge clk);
    in_valid  = iv;
    in_op     = op;
    in_amt    = amt;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall out_valid held", 32'(out_valid), 32'd1);
      check("stall out_data held", out_data, prev_data);
    end
    if (out_valid && !out_ready) check("stall in_ready", 32'(in_ready), 32'd0);
    acc = iv && in_ready;
    if (acc) exp_q.push_back(model(op, amt, d));
    if (out_valid && out_ready) begin
      n_got++;
      if (exp_q.size() == 0) check("unexpected output", out_data, 32'hxxxx_xxxx);
      else check("stream data", out_data, exp_q.pop_front());
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;

    vecs[0]  = '{OP_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{OP_SRA, 5'd4,  32'h8000_0000, 32'hF800_0000};
    vecs[2]  = '{OP_SRL, 5'd4,  32'h8000_0000, 32'h0800_0000};
    vecs[3]  = '{OP_ROR, 5'd8,  32'h1234_5678, 32'h7812_3456};
    vecs[4]  = '{OP_ROR, 5'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[5]  = '{OP_SLL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6]  = '{OP_SRA, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_SRL, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[9]  = '{OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000};
    vecs[10] = '{OP_SLL, 5'd4,  32'h1234_5678, 32'h2345_6780};
    vecs[11] = '{OP_SRL, 5'd12, 32'h1234_5678, 32'h0001_2345};
    vecs[12] = '{OP_ROR, 5'd31, 32'h1234_5678, 32'h2468_ACF0};
    vecs[13] = '{OP_SRA, 5'd3,  32'hF000_0000, 32'hFE00_0000};
    vecs[14] = '{OP_SLL, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'h0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // 16 back-to-back words with a 3-cycle downstream stall mid-stream.
    exp_q.delete();
    n_got = 0;
    sent  = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 200 && n_got < 16; c++) begin
      do_cycle(sent < 16, 2'(sent), 5'((sent * 7 + 1) % 32),
               32'h9E37_79B9 * 32'(sent + 1), !(c >= 8 && c <= 10), acc);
      if (acc) sent++;
    end
    check("stream words out", 32'(n_got), 32'd16);
    check("stream queue empty", 32'(exp_q.size()), 32'd0);

    // Reset with three words in flight plus one presented during reset.
    prev_stall = 1'b0;
    for (int c = 0; c < 3; c++) do_cycle(1'b1, 2'b11, 5'd4, 32'hC0DE_0000 + 32'(c), 1'b1, acc);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    in_amt   = 5'd1;
    #1;
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post reset out_valid", 32'(out_valid), 32'd0);
    check("post reset out_data", out_data, 32'h0);
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("post reset quiet %0d", c), 32'(out_valid), 32'd0);
    end
    run_vec('{OP_SRL, 5'd8, 32'hCAFE_F00D, 32'h00CA_FEF0}, 99);

    // Randomized traffic with random valid/ready against the model.
    exp_q.delete();
    prev_stall = 1'b0;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      do_cycle(($urandom % 4) != 0, 2'($urandom), 5'($urandom), $urandom,
               ($urandom % 4) != 0, acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 100 && exp_q.size() > 0; c++)
      do_cycle(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, acc);
    check("random words sent", 32'(sent), 32'd10000);
    check("random drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
